// File: rtl/buzzer_arbiter.sv
// Arbitrates the four lock sound sources onto one piezo buzzer pin.
// Pending requests are latched and played in priority order: err > ok > key > tick.
module buzzer_arbiter #(
  parameter int unsigned KEY_HALF   = 32'd50000,
  parameter int unsigned KEY_LEN    = 32'd10000000,
  parameter int unsigned OK_HALF    = 32'd25000,
  parameter int unsigned OK_LEN     = 32'd30000000,
  parameter int unsigned ERR_HALF   = 32'd100000,
  parameter int unsigned ERR_LEN    = 32'd15000000,
  parameter int unsigned ERR_GAP_LO = 32'd5000000,
  parameter int unsigned ERR_GAP_HI = 32'd10000000,
  parameter int unsigned TICK_HALF  = 32'd100000,
  parameter int unsigned TICK_LEN   = 32'd5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_key,
  input  logic       req_ok,
  input  logic       req_err,
  input  logic       req_tick,
  output logic       buzzer,
  output logic       busy,
  output logic [2:0] active_src
);

  typedef enum logic {S_IDLE = 1'b0, S_PLAY = 1'b1} state_e;

  localparam logic [2:0] SRC_NONE = 3'd0;
  localparam logic [2:0] SRC_TICK = 3'd1;
  localparam logic [2:0] SRC_KEY  = 3'd2;
  localparam logic [2:0] SRC_OK   = 3'd3;
  localparam logic [2:0] SRC_ERR  = 3'd4;

  // Request/pending vectors are ordered {err, ok, key, tick}.
  function automatic logic [2:0] top_src(input logic [3:0] v);
    if (v[3])      return SRC_ERR;
    else if (v[2]) return SRC_OK;
    else if (v[1]) return SRC_KEY;
    else if (v[0]) return SRC_TICK;
    else           return SRC_NONE;
  endfunction

  function automatic logic [3:0] src_mask(input logic [2:0] s);
    case (s)
      SRC_TICK: return 4'b0001;
      SRC_KEY:  return 4'b0010;
      SRC_OK:   return 4'b0100;
      SRC_ERR:  return 4'b1000;
      default:  return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] half_m1(input logic [2:0] s);
    case (s)
      SRC_TICK: return TICK_HALF - 32'd1;
      SRC_KEY:  return KEY_HALF - 32'd1;
      SRC_OK:   return OK_HALF - 32'd1;
      SRC_ERR:  return ERR_HALF - 32'd1;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] len_m1(input logic [2:0] s);
    case (s)
      SRC_TICK: return TICK_LEN - 32'd1;
      SRC_KEY:  return KEY_LEN - 32'd1;
      SRC_OK:   return OK_LEN - 32'd1;
      SRC_ERR:  return ERR_LEN - 32'd1;
      default:  return 32'd0;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  src_q, src_d;
  logic [3:0]  pending_q, pending_d;
  logic [31:0] half_q, half_d;
  logic [31:0] dur_q, dur_d;
  logic        tone_q, tone_d;
  logic        buzzer_q, buzzer_d;
  logic [3:0]  req_v;
  logic [3:0]  clr_v;
  logic [2:0]  req_top;

  assign req_v   = {req_err, req_ok, req_key, req_tick};
  assign req_top = top_src(req_v);

  // Next-state: grant, preempt, retrigger, tone timing and end-of-tone.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    half_d  = half_q;
    dur_d   = dur_q;
    tone_d  = tone_q;
    clr_v   = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if ((pending_q | req_v) != 4'b0000) begin
          state_d = S_PLAY;
          src_d   = top_src(pending_q | req_v);
          clr_v   = src_mask(top_src(pending_q | req_v));
          half_d  = 32'd0;
          dur_d   = 32'd0;
          tone_d  = 1'b1;
        end else begin
          tone_d  = 1'b0;
        end
      end
      S_PLAY: begin
        if (req_top > src_q) begin
          src_d  = req_top;
          clr_v  = src_mask(req_top);
          half_d = 32'd0;
          dur_d  = 32'd0;
          tone_d = 1'b1;
        end else if ((req_v & src_mask(src_q)) != 4'b0000) begin
          // Retrigger: the active source's own request is consumed, never pended.
          clr_v  = src_mask(src_q);
          half_d = 32'd0;
          dur_d  = 32'd0;
          tone_d = 1'b1;
        end else if (dur_q == len_m1(src_q)) begin
          state_d = S_IDLE;
          src_d   = SRC_NONE;
          half_d  = 32'd0;
          dur_d   = 32'd0;
          tone_d  = 1'b0;
        end else begin
          dur_d = dur_q + 32'd1;
          if (half_q == half_m1(src_q)) begin
            half_d = 32'd0;
            tone_d = ~tone_q;
          end else begin
            half_d = half_q + 32'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        src_d   = SRC_NONE;
        half_d  = 32'd0;
        dur_d   = 32'd0;
        tone_d  = 1'b0;
      end
    endcase
    pending_d = (pending_q | req_v) & ~clr_v;
    // The failure gap only masks the pin; the tone keeps toggling underneath.
    if ((src_d == SRC_ERR) && (dur_d >= ERR_GAP_LO) && (dur_d < ERR_GAP_HI)) begin
      buzzer_d = 1'b0;
    end else begin
      buzzer_d = tone_d;
    end
  end

  // State, counters and the registered buzzer drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_q     <= SRC_NONE;
      pending_q <= 4'b0000;
      half_q    <= 32'd0;
      dur_q     <= 32'd0;
      tone_q    <= 1'b0;
      buzzer_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      pending_q <= pending_d;
      half_q    <= half_d;
      dur_q     <= dur_d;
      tone_q    <= tone_d;
      buzzer_q  <= buzzer_d;
    end
  end

  assign buzzer     = buzzer_q;
  assign busy       = (state_q == S_PLAY);
  assign active_src = src_q;

endmodule
